// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// mem_arbiter_pkg
// Shared state encodings, client IDs and default sizes for the memory arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    localparam logic ARB_I = 1'b0;
    localparam logic ARB_D = 1'b1;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_ADDR_W = 28;
    localparam int DEF_BEATS  = 4;

endpackage

`default_nettype wire

// File: rtl/mem_arb_rr.sv
// ============================================================================
// mem_arb_rr
// Two-input round-robin picker: on a tie the client that did not win last.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arb_rr
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       any_o
);

    always_comb begin
        any_o = |valid_i;
        if (&valid_i) begin
            grant_o = ~last_grant_i;
        end else begin
            grant_o = valid_i[1] ? ARB_D : ARB_I;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter
// Shares one burst memory port between icache and dcache refill engines.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BEATS  = DEF_BEATS
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_resp_data,

    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_rw,
    input  logic              d_wdata_valid,
    output logic              d_wdata_ready,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_rw,
    output logic              mem_wdata_valid,
    input  logic              mem_wdata_ready,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
);

    localparam int CNT_W = $clog2(BEATS);

    state_t            state_q;
    logic              grant_q;
    logic              last_grant_q;
    logic              rw_q;
    logic              mem_req_valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              rr_grant;
    logic              rr_any;
    logic              in_idle;
    logic              in_wdata;
    logic              in_rdata;
    logic              wbeat;
    logic              last_cnt;

    mem_arb_rr u_rr (
        .valid_i      ({d_req_valid, i_req_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (rr_grant),
        .any_o        (rr_any)
    );

    assign in_idle  = (state_q == ST_IDLE);
    assign in_wdata = (state_q == ST_WDATA);
    assign in_rdata = (state_q == ST_RDATA);
    assign wbeat    = in_wdata & d_wdata_valid & mem_wdata_ready;
    assign last_cnt = (cnt_q == CNT_W'(BEATS - 1));

    // Acceptance is same-cycle: ready depends only on the picker result.
    assign i_req_ready = in_idle & rr_any & (rr_grant == ARB_I);
    assign d_req_ready = in_idle & rr_any & (rr_grant == ARB_D);

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_rw    = rw_q;

    assign mem_wdata_valid = in_wdata & d_wdata_valid;
    assign d_wdata_ready   = in_wdata & mem_wdata_ready;
    assign mem_wdata       = in_wdata ? d_wdata : '0;

    // Read beats go only to the granted client; stray beats elsewhere are dropped.
    assign i_resp_valid = in_rdata & (grant_q == ARB_I) & mem_resp_valid;
    assign d_resp_valid = in_rdata & (grant_q == ARB_D) & mem_resp_valid;
    assign i_resp_data  = i_resp_valid ? mem_resp_data : '0;
    assign d_resp_data  = d_resp_valid ? mem_resp_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            grant_q         <= ARB_I;
            last_grant_q    <= ARB_I;
            rw_q            <= 1'b0;
            mem_req_valid_q <= 1'b0;
            addr_q          <= '0;
            cnt_q           <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rr_any) begin
                        grant_q         <= rr_grant;
                        last_grant_q    <= rr_grant;
                        addr_q          <= (rr_grant == ARB_D) ? d_req_addr : i_req_addr;
                        rw_q            <= (rr_grant == ARB_D) & d_req_rw;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        cnt_q           <= '0;
                        state_q         <= rw_q ? ST_WDATA : ST_RDATA;
                    end
                end
                ST_WDATA: begin
                    if (wbeat) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_cnt) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_RDATA: begin
                    if (mem_resp_valid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_cnt) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
